// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Pulls words out of a synchronous FIFO with RD_LATENCY read latency and
//   presents them as a valid/ready stream. Reads are issued on a credit basis,
//   so every issued read always has a free slot in the small elastic buffer
//   that absorbs the read latency. Because of this, the buffer can never
//   overflow and a stalled sink can never cause a word to be lost.
//
// Parameters
//   DWIDTH      data width
//   RD_LATENCY  cycles from an accepted read to rd_data valid (1 or 2)
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   rd_en       FIFO pop request (only ever asserted while rd_empty=0)
//   rd_empty    FIFO empty flag
//   rd_data     FIFO read data, sampled RD_LATENCY cycles after a pop
//   flush       drops all buffered and in-flight words (synchronous)
//   m_valid     stream word valid
//   m_ready     stream sink ready
//   m_data      stream word (head of the elastic buffer)
//   word_cnt    running count of stream handshakes, wraps at 2^32
module fifo_stream_reader #(
  parameter int DWIDTH     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rd_en,
  input  logic              rd_empty,
  input  logic [DWIDTH-1:0] rd_data,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [31:0]       word_cnt
);

  // One slot per cycle of read latency plus one for the word being
  // presented, which is what full-rate streaming needs.
  localparam int BUF_DEPTH = RD_LATENCY + 1;
  localparam int PW        = $clog2(BUF_DEPTH);
  localparam int OW        = $clog2(BUF_DEPTH + 1);
  localparam int CW        = OW + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

  // run_q holds off reads until the first edge after reset release.
  logic                              run_q;
  // vld_pipe_q[k]: a read issued k cycles ago is still in flight.
  logic [RD_LATENCY:1]               vld_pipe_q, vld_pipe_d;
  logic [BUF_DEPTH-1:0][DWIDTH-1:0]  mem_q;
  logic [PW-1:0]                     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                     rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]                     occ_q, occ_d;
  logic [31:0]                       word_cnt_q, word_cnt_d;

  logic          hs;
  logic          cap;
  logic [CW-1:0] infl;
  logic [CW-1:0] credits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign m_valid  = (occ_q != '0);
  assign m_data   = mem_q[rd_ptr_q];
  assign word_cnt = word_cnt_q;

  assign hs  = m_valid & m_ready;
  // A word returning in a flush cycle belongs to a discarded read.
  assign cap = vld_pipe_q[RD_LATENCY] & ~flush;

  always_comb begin
    infl = '0;
    for (int k = 1; k <= RD_LATENCY; k++) infl = infl + CW'(vld_pipe_q[k]);
  end

  // occ + in-flight never exceeds BUF_DEPTH, so this cannot go negative.
  // The pop in this cycle frees its slot early so reads keep pace with
  // the sink without a bubble.
  assign credits = CW'(BUF_DEPTH) - CW'(occ_q) - infl + CW'(hs);

  assign rd_en = run_q & ~rd_empty & ~flush & (credits != '0);

  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[1] = rd_en;
    for (int k = 2; k <= RD_LATENCY; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    if (flush) vld_pipe_d = '0;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q + OW'(cap) - OW'(hs);
    word_cnt_d = word_cnt_q + 32'(hs);
    if (cap) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (hs)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   mem_q <= '0;
    else if (cap) mem_q[wr_ptr_q] <= rd_data;
  end

endmodule
